uart_baud_ctrl: RTL
===================

// Module: uart_baud_ctrl
// PURPOSE
// Sequencer for uart_baud_clkgen: owns its reset and cfg_div_ratio, applies divisor changes
// only on baud-period boundaries, waits for the generator to settle, then reports lock.
// Emits a one-cycle o_baud_tick per baud rising edge for UART TX/RX.
// Sits between the host config interface and the baud generator, in the same clock domain.
// PARAMETERS
// DIV_W        16     divisor width; must match generator cfg_div_ratio
// DEF_DIV      6      divisor driven out of reset
// MIN_DIV      2      smallest legal divisor; smaller requests are rejected
// RST_CYCLES   2      cycles o_gen_rst is held high on each (re)start, >=1
// SETTLE_TICKS 2      baud rising edges counted before lock, >=1
// PORTS
// i_clk        in   1      system clock, shared with generator
// i_rst_n      in   1      asynchronous active-low reset
// i_enable     in   1      level; 1 = run generator, 0 = hold it in reset
// i_cfg_valid  in   1      new divisor request
// i_cfg_div    in   DIV_W  requested divisor
// o_cfg_ready  out  1      request accepted when i_cfg_valid & o_cfg_ready
// o_cfg_err    out  1      1-cycle pulse: accepted request had i_cfg_div < MIN_DIV
// o_div_ratio  out  DIV_W  to generator cfg_div_ratio
// o_gen_rst    out  1      to generator i_rst (active high)
// i_baud_clk   in   1      from generator o_baud_clk
// o_baud_tick  out  1      1-cycle pulse per baud rising edge, LOCKED only
// o_locked     out  1      1 while in LOCKED
// o_state      out  3      FSM state, for debug
// BEHAVIOUR
// - Reset: state=OFF, o_div_ratio=DEF_DIV, o_gen_rst=1, o_cfg_ready=1, o_locked=0,
//   o_baud_tick=0, o_cfg_err=0, edge register=0, pending div=DEF_DIV, counters=0.
// - Edge detect: baud_q<=i_baud_clk; rise = i_baud_clk & ~baud_q (comb).
//   o_baud_tick <= rise & (state==LOCKED): one cycle after the rise is sampled.
// - States (o_state): OFF=0 START=1 SETTLE=2 LOCKED=3 WAIT_EDGE=4. All outputs registered.
//   OFF: o_gen_rst=1. i_enable=1 -> START.
//   START: o_gen_rst=1 for exactly RST_CYCLES cycles, counter starts at 0 on entry -> SETTLE.
//   SETTLE: o_gen_rst=0; count rises; SETTLE_TICKS-th rise -> LOCKED next cycle.
//   LOCKED: o_locked=1. Accepted legal request -> latch pending div -> WAIT_EDGE.
//   WAIT_EDGE: generator still running on old div; next rise -> START, o_div_ratio<=pending
//   in the same edge that enters START. Edge in the request cycle is not counted.
// - o_cfg_ready=1 in OFF and LOCKED only; at most one request in flight.
// - Accepted request in OFF: legal div written to o_div_ratio next cycle, state stays OFF.
// - Illegal request (i_cfg_div < MIN_DIV): handshake completes, o_cfg_err pulses 1 cycle,
//   o_div_ratio and state unchanged.
// - i_enable=0 in any state: OFF next cycle, o_locked=0, o_gen_rst=1, counters cleared,
//   pending request dropped (o_div_ratio keeps last applied value). Takes priority over
//   every other transition; a request accepted that same cycle still updates o_div_ratio
//   (legal) or pulses o_cfg_err (illegal).
// - i_rst_n asserted mid-operation: all state returns to reset values immediately.
// CONFIGURATION
// UART_BAUD_WDOG_EN defined: adds output o_fault (1 bit, reset 0) and a 17-bit watchdog
//   counter in SETTLE/LOCKED/WAIT_EDGE, cleared on every rise and on state entry. If it reaches
//   {o_div_ratio,1'b0}+4 with no rise: o_fault pulses 1 cycle, state -> START (restart,
//   o_div_ratio unchanged, pending dropped).
// UART_BAUD_WDOG_EN undefined: no o_fault port, no watchdog; a stalled generator leaves
//   the FSM waiting indefinitely.
// TESTING
// 1 Reset, i_enable=0 for 10 cycles -> o_gen_rst=1, o_div_ratio=6, o_state=0, o_cfg_ready=1.
// 2 i_enable 0->1 -> o_state=1 for 2 cycles with o_gen_rst=1, then SETTLE; o_locked=1 the
//   cycle after the 2nd baud rise; o_baud_tick then pulses once per rise, 1 cycle after it.
// 3 LOCKED, request div=10 -> o_cfg_ready drops, o_div_ratio stays 6 until next rise,
//   then =10 with o_state=1; relock after 2 rises at the new rate.
// 4 Request div=1 in LOCKED -> o_cfg_err one-cycle pulse, o_div_ratio=6, o_locked stays 1.
// 5 i_enable dropped in WAIT_EDGE with pending div=8 -> OFF next cycle, o_div_ratio=6,
//   o_locked=0, o_gen_rst=1; re-enable relocks at div 6.
// 6 UART_BAUD_WDOG_EN, force i_baud_clk=0 in LOCKED at div 6 -> o_fault pulse after 16
//   cycles without a rise, o_state=1.

Source files
------------

// File: rtl/uart_baud_ctrl.sv
// -----------------------------------------------------------------------------
// uart_baud_ctrl
//
// Sequencer for a uart_baud_clkgen instance in the same clock domain. It owns
// the generator's reset and divisor. Divisor changes are applied only on a baud
// period boundary. After each (re)start the block waits for the generator to
// settle, then reports lock. While locked it emits a one-cycle tick per baud
// rising edge.
//
// Optional feature (macro UART_BAUD_WDOG_EN):
//   This macro adds the o_fault output and a watchdog. The watchdog restarts
//   the generator when no baud rising edge arrives within 2*div+4 cycles while
//   the FSM is in SETTLE, LOCKED or WAIT_EDGE.
//
// Ports:
//   i_clk        system clock, shared with the generator
//   i_rst_n      asynchronous active-low reset
//   i_enable     1 = run generator, 0 = hold it in reset (level)
//   i_cfg_valid  new divisor request
//   i_cfg_div    requested divisor
//   o_cfg_ready  request accepted when i_cfg_valid & o_cfg_ready
//   o_cfg_err    1-cycle pulse: accepted request was below MIN_DIV
//   o_div_ratio  divisor driven to the generator
//   o_gen_rst    generator reset (active high)
//   i_baud_clk   baud clock from the generator
//   o_baud_tick  1-cycle pulse per baud rising edge, only while locked
//   o_locked     1 while in LOCKED
//   o_state      FSM state, for debug
//   o_fault      (UART_BAUD_WDOG_EN only) 1-cycle pulse on watchdog restart
// -----------------------------------------------------------------------------
module uart_baud_ctrl #(
    parameter int DIV_W        = 16,
    parameter int DEF_DIV      = 6,
    parameter int MIN_DIV      = 2,
    parameter int RST_CYCLES   = 2,
    parameter int SETTLE_TICKS = 2
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_enable,
    input  logic             i_cfg_valid,
    input  logic [DIV_W-1:0] i_cfg_div,
    output logic             o_cfg_ready,
    output logic             o_cfg_err,
    output logic [DIV_W-1:0] o_div_ratio,
    output logic             o_gen_rst,
    input  logic             i_baud_clk,
    output logic             o_baud_tick,
    output logic             o_locked,
`ifdef UART_BAUD_WDOG_EN
    output logic             o_fault,
`endif
    output logic [2:0]       o_state
);

    typedef enum logic [2:0] {
        ST_OFF       = 3'd0,
        ST_START     = 3'd1,
        ST_SETTLE    = 3'd2,
        ST_LOCKED    = 3'd3,
        ST_WAIT_EDGE = 3'd4
    } state_t;

    // Counters only need to reach their terminal value (N-1).
    localparam int RST_W = (RST_CYCLES   > 1) ? $clog2(RST_CYCLES)   : 1;
    localparam int SET_W = (SETTLE_TICKS > 1) ? $clog2(SETTLE_TICKS) : 1;

    localparam logic [RST_W-1:0] RST_LAST = RST_W'(RST_CYCLES - 1);
    localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_TICKS - 1);
    localparam logic [DIV_W-1:0] DIV_MIN  = DIV_W'(MIN_DIV);
    localparam logic [DIV_W-1:0] DIV_DEF  = DIV_W'(DEF_DIV);

    state_t             state_q, state_d;
    logic [RST_W-1:0]   rst_cnt_q, rst_cnt_d;
    logic [SET_W-1:0]   set_cnt_q, set_cnt_d;
    logic [DIV_W-1:0]   pend_q, pend_d;
    logic [DIV_W-1:0]   div_d;
    logic               baud_q;
    logic               rise;
    logic               accept;
    logic               legal;

    assign rise    = i_baud_clk & ~baud_q;
    assign accept  = i_cfg_valid & o_cfg_ready;
    assign legal   = (i_cfg_div >= DIV_MIN);
    assign o_state = state_q;

`ifdef UART_BAUD_WDOG_EN
    // One bit wider than the divisor so that 2*div+4 fits.
    logic [DIV_W:0] wdog_q, wdog_d;
    logic [DIV_W:0] wdog_inc;
    logic [DIV_W:0] wdog_limit;
    logic           watched;
    logic           wdog_hit;

    assign watched    = (state_q == ST_SETTLE) || (state_q == ST_LOCKED) ||
                        (state_q == ST_WAIT_EDGE);
    assign wdog_inc   = wdog_q + 1'b1;
    assign wdog_limit = {o_div_ratio, 1'b0} + (DIV_W+1)'(4);
    // This cycle would be the limit-th consecutive one without a rise.
    assign wdog_hit   = watched & ~rise & (wdog_inc == wdog_limit);
`endif

    // NOTE: every variable gets a default before any branch, so no path leaves
    // a value unassigned and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        rst_cnt_d = rst_cnt_q;
        set_cnt_d = set_cnt_q;
        pend_d    = pend_q;
        div_d     = o_div_ratio;

        if (!i_enable) begin
            // Disable wins. A request accepted in this cycle still lands.
            state_d = ST_OFF;
            if (accept && legal) div_d = i_cfg_div;
        end
`ifdef UART_BAUD_WDOG_EN
        else if (wdog_hit) begin
            state_d = ST_START;
        end
`endif
        else begin
            case (state_q)
                ST_OFF: begin
                    if (accept && legal) div_d = i_cfg_div;
                    state_d = ST_START;
                end
                ST_START: begin
                    if (rst_cnt_q == RST_LAST) state_d = ST_SETTLE;
                    else                       rst_cnt_d = rst_cnt_q + 1'b1;
                end
                ST_SETTLE: begin
                    if (rise) begin
                        if (set_cnt_q == SET_LAST) state_d = ST_LOCKED;
                        else                       set_cnt_d = set_cnt_q + 1'b1;
                    end
                end
                ST_LOCKED: begin
                    if (accept && legal) begin
                        pend_d  = i_cfg_div;
                        state_d = ST_WAIT_EDGE;
                    end
                end
                ST_WAIT_EDGE: begin
                    // The generator keeps running on the old divisor. The new
                    // divisor is applied on the edge that enters START.
                    if (rise) begin
                        div_d   = pend_q;
                        state_d = ST_START;
                    end
                end
                default: state_d = ST_OFF;
            endcase
        end

        // Each state starts its counters from zero.
        if (state_d != state_q) begin
            rst_cnt_d = '0;
            set_cnt_d = '0;
        end
    end

`ifdef UART_BAUD_WDOG_EN
    always_comb begin
        wdog_d = wdog_inc;
        if (!watched || rise || (state_d != state_q)) wdog_d = '0;
    end
`endif

    // NOTE: state elements use non-blocking assignments. All flops then
    // update together from pre-edge values, with no ordering races.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= ST_OFF;
            rst_cnt_q   <= '0;
            set_cnt_q   <= '0;
            pend_q      <= DIV_DEF;
            o_div_ratio <= DIV_DEF;
            baud_q      <= 1'b0;
            o_gen_rst   <= 1'b1;
            o_cfg_ready <= 1'b1;
            o_locked    <= 1'b0;
            o_baud_tick <= 1'b0;
            o_cfg_err   <= 1'b0;
        end else begin
            state_q     <= state_d;
            rst_cnt_q   <= rst_cnt_d;
            set_cnt_q   <= set_cnt_d;
            pend_q      <= pend_d;
            o_div_ratio <= div_d;
            baud_q      <= i_baud_clk;
            // Outputs are decoded from the next state, so they line up with
            // state_q after the edge.
            o_gen_rst   <= (state_d == ST_OFF) || (state_d == ST_START);
            o_cfg_ready <= (state_d == ST_OFF) || (state_d == ST_LOCKED);
            o_locked    <= (state_d == ST_LOCKED);
            o_baud_tick <= rise && (state_q == ST_LOCKED);
            o_cfg_err   <= accept && !legal;
        end
    end

`ifdef UART_BAUD_WDOG_EN
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wdog_q  <= '0;
            o_fault <= 1'b0;
        end else begin
            wdog_q  <= wdog_d;
            o_fault <= wdog_hit && i_enable;
        end
    end
`endif

endmodule
